// File: rtl/hazard_forward_unit_if.sv
// ID/EX/MEM hazard bus between the pipeline and hazard_forward_unit.
// Optional stall_cnt exists only when HFU_STALL_CNT_EN is defined.
interface hazard_forward_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
  logic [NUM_SRC-1:0] id_src_valid;
  logic id_valid;
  logic id_md_start;
  logic [REG_ADDR_W-1:0] id_md_dst;
  logic [REG_ADDR_W-1:0] ex_dst;
  logic ex_wr_en;
  logic ex_is_load;
  logic [REG_ADDR_W-1:0] mem_dst;
  logic mem_wr_en;
  logic [2*NUM_SRC-1:0] fwd_sel;
  logic stall_if;
  logic stall_id;
  logic flush_ex;
  logic md_busy;
  logic md_done;
`ifdef HFU_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  modport master (
`ifdef HFU_STALL_CNT_EN
    input stall_cnt,
`endif
    output id_src, id_src_valid, id_valid,
    output id_md_start, id_md_dst,
    output ex_dst, ex_wr_en, ex_is_load,
    output mem_dst, mem_wr_en,
    input fwd_sel, stall_if, stall_id, flush_ex,
    input md_busy, md_done
  );

  modport slave (
`ifdef HFU_STALL_CNT_EN
    output stall_cnt,
`endif
    input id_src, id_src_valid, id_valid,
    input id_md_start, id_md_dst,
    input ex_dst, ex_wr_en, ex_is_load,
    input mem_dst, mem_wr_en,
    output fwd_sel, stall_if, stall_id, flush_ex,
    output md_busy, md_done
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// ID/EX hazard detection, registered forwarding selects and mul/div tracking.
// Define HFU_STALL_CNT_EN to add a saturating 16-bit stall cycle counter.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC = 2,
  parameter int MD_LAT = 4
) (
  input logic clk,
  input logic reset,
  hazard_forward_unit_if.slave bus
);
  localparam int CW = $clog2(MD_LAT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_t;

  md_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] md_dst_q, md_dst_d;
  logic [2*NUM_SRC-1:0] fwd_q, fwd_d;
  logic [NUM_SRC-1:0] live, hit_ex, hit_mem, hit_md;
  logic load_use, md_hazard, stall, md_busy;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_ADDR_W-1:0] src;
    assign src = bus.id_src[k*REG_ADDR_W +: REG_ADDR_W];
    assign live[k] = bus.id_valid && bus.id_src_valid[k]
                     && (src != '0);
    assign hit_ex[k] = live[k] && bus.ex_wr_en
                       && (src == bus.ex_dst);
    assign hit_mem[k] = live[k] && bus.mem_wr_en
                        && (src == bus.mem_dst);
    assign hit_md[k] = live[k] && (src == md_dst_q);
    // EX producer wins over MEM: it is the younger write
    assign fwd_d[2*k +: 2] =
      stall                         ? 2'b00 :
      (hit_ex[k] && !bus.ex_is_load) ? 2'b01 :
      hit_mem[k]                    ? 2'b10 : 2'b00;
  end

  assign md_busy = (state_q != IDLE);
  assign load_use = bus.ex_is_load && (|hit_ex);
  assign md_hazard = md_busy && ((|hit_md) || bus.id_md_start);
  assign stall = reset && (load_use || md_hazard);

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    md_dst_d = md_dst_q;
    unique case (state_q)
      IDLE: begin
        if (bus.id_md_start && bus.id_valid && !stall) begin
          state_d = BUSY;
          cnt_d = CW'(MD_LAT - 1);
          md_dst_d = bus.id_md_dst;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      md_dst_q <= '0;
      fwd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      md_dst_q <= md_dst_d;
      fwd_q <= fwd_d;
    end
  end

  assign bus.fwd_sel = fwd_q;
  assign bus.stall_if = stall;
  assign bus.stall_id = stall;
  assign bus.flush_ex = stall;
  assign bus.md_busy = md_busy;
  assign bus.md_done = (state_q == DONE);

`ifdef HFU_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end
  assign bus.stall_cnt = stall_cnt_q;
`else
  // no stall counter in this build
`endif
endmodule
